// File: rtl/freq_meter.sv
// Gated edge-counting frequency meter: counts synchronized rising edges of sig_in per GATE_CYCLES window.
// Optional macro FREQ_METER_PERIOD_EN adds an edge-to-edge period measurement.
module freq_meter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int COUNT_W     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               sig_in,
  input  logic               enable,
  output logic [COUNT_W-1:0] freq_count,
  output logic               count_valid,
  output logic               overflow,
`ifdef FREQ_METER_PERIOD_EN
  output logic [COUNT_W-1:0] period_cnt,
  output logic               period_valid,
`endif
  output logic               busy
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam int AW = $clog2(SYNC_STAGES + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [AW-1:0] ARM_LAST  = AW'(SYNC_STAGES);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE} state_t;

  state_t             r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic               r_sync_d;
  logic [GW-1:0]      r_gate_cnt;
  logic [AW-1:0]      r_arm_cnt;
  logic [COUNT_W-1:0] r_edge_cnt;
  logic               r_sat;
  logic [COUNT_W-1:0] r_freq_count;
  logic               r_count_valid;
  logic               r_overflow;
  logic               r_busy;

  logic               w_edge;
  logic               w_cnt_max;
  logic [COUNT_W-1:0] w_cnt_next;
  logic               w_sat_next;

  // Synchronizer chain; runs in every state so the detector is primed before MEASURE.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n)
          r_sync[gi] <= 1'b0;
        else if (gi == 0)
          r_sync[gi] <= sig_in;
        else
          r_sync[gi] <= r_sync[(gi == 0) ? 0 : gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)
      r_sync_d <= 1'b0;
    else
      r_sync_d <= r_sync[SYNC_STAGES-1];
  end

  assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_sync_d;
  assign w_cnt_max  = &r_edge_cnt;
  assign w_cnt_next = r_edge_cnt + COUNT_W'(w_edge & ~w_cnt_max);
  assign w_sat_next = r_sat | (w_edge & w_cnt_max);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_gate_cnt    <= '0;
      r_arm_cnt     <= '0;
      r_edge_cnt    <= '0;
      r_sat         <= 1'b0;
      r_freq_count  <= '0;
      r_count_valid <= 1'b0;
      r_overflow    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_count_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_gate_cnt <= '0;
          r_arm_cnt  <= '0;
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
          if (enable) begin
            r_state <= S_ARM;
            r_busy  <= 1'b1;
          end
        end
        S_ARM: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_arm_cnt == ARM_LAST) begin
            r_state    <= S_MEASURE;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
          end else begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
          end
        end
        S_MEASURE: begin
          if (!enable) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
          end else if (r_gate_cnt == GATE_LAST) begin
            // Terminal cycle's own edge is folded in; next window starts with no gap.
            r_freq_count  <= w_cnt_next;
            r_overflow    <= w_sat_next;
            r_count_valid <= 1'b1;
            r_gate_cnt    <= '0;
            r_edge_cnt    <= '0;
            r_sat         <= 1'b0;
          end else begin
            r_gate_cnt <= r_gate_cnt + 1'b1;
            r_edge_cnt <= w_cnt_next;
            r_sat      <= w_sat_next;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign freq_count  = r_freq_count;
  assign count_valid = r_count_valid;
  assign overflow    = r_overflow;
  assign busy        = r_busy;

`ifdef FREQ_METER_PERIOD_EN
  logic [COUNT_W-1:0] r_period_run;
  logic [COUNT_W-1:0] r_period_cnt;
  logic               r_period_valid;
  logic               r_have_edge;
  logic               w_meas;
  logic               w_run_max;

  assign w_meas    = (r_state == S_MEASURE) && enable;
  assign w_run_max = &r_period_run;

  // Running counter holds cycles-since-last-edge minus one; the published value adds the edge cycle.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_period_run   <= '0;
      r_period_cnt   <= '0;
      r_period_valid <= 1'b0;
      r_have_edge    <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      if (r_state != S_MEASURE) begin
        r_have_edge  <= 1'b0;
        r_period_run <= '0;
      end else if (w_meas) begin
        if (w_edge) begin
          r_period_run <= '0;
          r_have_edge  <= 1'b1;
          if (r_have_edge) begin
            r_period_cnt   <= w_run_max ? r_period_run : r_period_run + 1'b1;
            r_period_valid <= 1'b1;
          end
        end else if (!w_run_max) begin
          r_period_run <= r_period_run + 1'b1;
        end
      end
    end
  end

  assign period_cnt   = r_period_cnt;
  assign period_valid = r_period_valid;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter: two instances (32-bit and 4-bit counters) checked each cycle
// against a window-arithmetic reference model.
module tb_freq_meter;
  localparam int G  = 100;
  localparam int SS = 2;

  logic clk_in = 1'b0;
  logic reset_n, sig_in, enable;
  logic [31:0] freq32;
  logic [3:0]  freq4;
  logic cv32, cv4, ovf32, ovf4, busy32, busy4;
`ifdef FREQ_METER_PERIOD_EN
  logic [31:0] pc32;
  logic [3:0]  pc4;
  logic pv32, pv4;
`endif

  always #5 clk_in = ~clk_in;

  freq_meter #(.GATE_CYCLES(G), .COUNT_W(32), .SYNC_STAGES(SS)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .sig_in(sig_in), .enable(enable),
    .freq_count(freq32), .count_valid(cv32), .overflow(ovf32),
`ifdef FREQ_METER_PERIOD_EN
    .period_cnt(pc32), .period_valid(pv32),
`endif
    .busy(busy32));

  freq_meter #(.GATE_CYCLES(G), .COUNT_W(4), .SYNC_STAGES(SS)) dut4 (
    .clk_in(clk_in), .reset_n(reset_n), .sig_in(sig_in), .enable(enable),
    .freq_count(freq4), .count_valid(cv4), .overflow(ovf4),
`ifdef FREQ_METER_PERIOD_EN
    .period_cnt(pc4), .period_valid(pv4),
`endif
    .busy(busy4));

  int vectors = 0;
  int miscompares = 0;

  // Square-wave generator state
  int hp = 5;
  int ph = 0;

  // Reference model state
  int  n = 0;
  bit  s [0:16383];
  bit  idle = 1'b1;
  int  e0 = 0;
  int  wcnt = 0;
  int  have = 0;
  int  last = 0;
  logic [31:0] e_freq32 = 0, e_freq4 = 0, e_pc32 = 0, e_pc4 = 0;
  logic e_ovf4 = 0, e_cv = 0, e_busy = 0, e_pv = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, n, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step();
    bit det;
    int m;
    if (!reset_n) begin
      idle = 1'b1; s[n] = 1'b0; e_cv = 0; e_pv = 0;
      e_freq32 = 0; e_freq4 = 0; e_ovf4 = 0; e_pc32 = 0; e_pc4 = 0;
    end else begin
      s[n] = sig_in;
      det  = (n > SS) && s[n-SS] && !s[n-SS-1];
      e_cv = 0; e_pv = 0;
      if (idle) begin
        if (enable) begin idle = 1'b0; e0 = n; wcnt = 0; have = 0; end
      end else if (!enable) begin
        idle = 1'b1;
      end else begin
        m = n - e0;
        // ARM occupies edges e0+1..e0+SS+1; window edges follow in blocks of G.
        if (m >= SS + 2) begin
          if (det) begin
            wcnt++;
            if (have != 0) begin
              e_pv = 1; e_pc32 = n - last; e_pc4 = sat(n - last, 15);
            end
            have = 1; last = n;
          end
          if ((m - SS - 1) % G == 0) begin
            e_cv = 1;
            e_freq32 = wcnt;
            e_freq4 = sat(wcnt, 15);
            e_ovf4 = (wcnt > 15);
            wcnt = 0;
          end
        end
      end
    end
    e_busy = !idle;
    n++;
  endtask

  task automatic check_all();
    chk("freq32", freq32, e_freq32);
    chk("valid32", {31'b0, cv32}, {31'b0, e_cv});
    chk("ovf32", {31'b0, ovf32}, 32'd0);
    chk("busy32", {31'b0, busy32}, {31'b0, e_busy});
    chk("freq4", {28'b0, freq4}, e_freq4);
    chk("valid4", {31'b0, cv4}, {31'b0, e_cv});
    chk("ovf4", {31'b0, ovf4}, {31'b0, e_ovf4});
    chk("busy4", {31'b0, busy4}, {31'b0, e_busy});
`ifdef FREQ_METER_PERIOD_EN
    chk("pvalid32", {31'b0, pv32}, {31'b0, e_pv});
    chk("pcnt32", pc32, e_pc32);
    chk("pvalid4", {31'b0, pv4}, {31'b0, e_pv});
    chk("pcnt4", {28'b0, pc4}, e_pc4);
`endif
  endtask

  task automatic tick();
    if (ph >= hp - 1) begin sig_in = ~sig_in; ph = 0; end
    else ph++;
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    check_all();
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; sig_in = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    // Idle after reset: everything stays at zero
    repeat (200) tick();

    // Period-10 input: 10 edges per window
    enable = 1'b1;
    repeat (360) tick();
    chk("case2_freq", freq32, 32'd10);

    // Period 4: 25 per window; 4-bit instance saturates
    hp = 2;
    repeat (250) tick();
    chk("case3_freq", freq32, 32'd25);
    chk("case4_freq4", {28'b0, freq4}, 32'd15);
    chk("case4_ovf4", {31'b0, ovf4}, 32'd1);
    repeat ($urandom_range(20, 80)) tick();
    hp = 10;
    repeat (300) tick();
    chk("case3_slow", freq32, 32'd5);

    hp = 5;
    repeat (250) tick();
    chk("case4_freq4_ok", {28'b0, freq4}, 32'd10);
    chk("case4_ovf4_clr", {31'b0, ovf4}, 32'd0);

    // Abort mid-window, then re-arm
    repeat ($urandom_range(30, 90)) tick();
    enable = 1'b0;
    repeat (30) tick();
    enable = 1'b1;
    repeat (250) tick();

    // Asynchronous reset between clock edges
    repeat ($urandom_range(30, 70)) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("areset_freq", freq32, 32'd0);
    chk("areset_valid", {31'b0, cv32}, 32'd0);
    chk("areset_ovf4", {31'b0, ovf4}, 32'd0);
    chk("areset_busy", {31'b0, busy32}, 32'd0);
    repeat (5) tick();
    reset_n = 1'b1;
    repeat (250) tick();
    chk("case6_freq", freq32, 32'd10);
`ifdef FREQ_METER_PERIOD_EN
    chk("case6_period", pc32, 32'd10);
`endif

    // Random rates with occasional aborts
    repeat (5) begin
      hp = $urandom_range(2, 12);
      repeat (230) tick();
      if ($urandom_range(0, 2) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 6)) tick();
        enable = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
